s_type: RTL and testbench
=========================

S_TYPE -- requirements
Module: s_type

Interface
REQ-001 The block SHALL run on one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 All ports SHALL be carried by interface Instr_IO and reached through its modport S_type_io_ports; the module's only port is that modport.
REQ-003 Parameter XLEN, default 32, SHALL set the data/address width; only 32 is supported.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 idata  input  32  current instruction word; only bits 30, 25 and 14:12 are decoded.
REQ-007 iaddr  input  32  current instruction address; carried on the interface, unused by this block.
REQ-008 daddr  input  32  effective store address computed upstream (rs1 + S-immediate).
REQ-009 rv2  input  32  store source register value.
REQ-010 we_S  output  4  per-byte write enables, bit n = byte lane n of the aligned word.
REQ-011 wdata_S  output  32  lane-aligned store data.
REQ-012 misalign_S  output  1  combinational flag: current store is misaligned.
REQ-013 fault_S  output  1  registered sticky misaligned-store flag.
REQ-014 store_cnt  output  32  registered count of cycles with we_S != 0.

Function
REQ-015 Decode key SHALL be the 5-bit s_func = {idata[30], idata[25], idata[14:12]}: SB = 5'b00000, SH = 5'b00001, SW = 5'b00010.
REQ-016 The block SHALL NOT check the opcode; the top-level decoder gates its use to S-type cycles.
REQ-017 SB: we_S = 4'b0001 << daddr[1:0]; wdata_S = rv2[7:0] replicated to all four lanes.
REQ-018 SH: we_S = 4'b0011 when daddr[1] = 0, 4'b1100 when daddr[1] = 1; wdata_S = rv2[15:0] replicated to both halves.
REQ-019 SW: we_S = 4'b1111 regardless of daddr[1:0]; wdata_S = rv2.
REQ-020 Any other s_func value SHALL give we_S = 4'b0000, wdata_S = 0 and misalign_S = 0.
REQ-021 misalign_S SHALL be 1 for SH with daddr[0] = 1, and for SW with daddr[1:0] != 0; otherwise 0.
REQ-022 The outputs we_S, wdata_S and misalign_S SHALL be purely combinational, with zero-cycle latency and no dependence on clk.
REQ-023 misalign_S SHALL NOT suppress or modify we_S.
REQ-024 fault_S SHALL set on the rising clk edge where misalign_S = 1, and SHALL remain set until reset.
REQ-025 store_cnt SHALL increment by 1 on each rising clk edge where we_S != 0, and SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-026 Asserting reset SHALL immediately clear fault_S and store_cnt to 0, independent of clk.
REQ-027 The combinational outputs SHALL be unaffected by reset.
REQ-028 Reset asserted at the same edge as a counting or faulting event SHALL win.

Structure
REQ-029 The enum s_func (5-bit, members SB, SH, SW) SHALL live in shared package riscv_pkg, alongside the S-type funct3 constants.
REQ-030 Interface Instr_IO SHALL declare modport S_type_io_ports.
REQ-031 One sub-module SHALL be used, s_lane_align, to compute we_S, wdata_S and misalign_S from s_func, daddr[1:0] and rv2; the sticky flag and counter SHALL live in s_type.

Verification
REQ-032 SB with daddr = 1 and rv2 = 32'h0000_00AB -> we_S = 4'b0010, wdata_S = 32'hABAB_ABAB, misalign_S = 0.
REQ-033 SH with daddr = 0 -> we_S = 4'b0011; SH with daddr = 2 -> we_S = 4'b1100; SH with daddr = 3 -> misalign_S = 1.
REQ-034 SW with daddr = 1 -> we_S = 4'b1111 and misalign_S = 1; after one clk edge, fault_S = 1 and it stays 1.
REQ-035 SB with daddr = 0..3 -> we_S = 4'b0001, 4'b0010, 4'b0100, 4'b1000 respectively.
REQ-036 funct3 = 3'b011 -> we_S = 0; store_cnt does not increment.
REQ-037 Three clocked stores, then reset asserted mid-cycle -> store_cnt goes from 3 to 0 and fault_S goes to 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V decode types and S-type funct3 constants
package riscv_pkg;

    // Store decode key {idata[30], idata[25], funct3}.
    typedef enum logic [4:0] {
        SB = 5'b00000,
        SH = 5'b00001,
        SW = 5'b00010
    } s_func;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

endpackage

// File: rtl/instr_io.sv
// rtl/instr_io.sv - instruction-path interface carrying the S-type store signals
interface Instr_IO #(
    parameter int XLEN = 32
) ();
    logic            clk;
    logic            reset;
    logic [XLEN-1:0] idata;
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] daddr;
    logic [XLEN-1:0] rv2;
    logic [3:0]      we_S;
    logic [XLEN-1:0] wdata_S;
    logic            misalign_S;
    logic            fault_S;
    logic [XLEN-1:0] store_cnt;

    modport S_type_io_ports (
        input  clk,
        input  reset,
        input  idata,
        input  iaddr,
        input  daddr,
        input  rv2,
        output we_S,
        output wdata_S,
        output misalign_S,
        output fault_S,
        output store_cnt
    );
endinterface

// File: rtl/s_lane_align.sv
// rtl/s_lane_align.sv - combinational byte-lane enables, data replication and misalign detect
module s_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  s_func           func_i,
    input  logic [1:0]      addr_i,
    input  logic [XLEN-1:0] rv2_i,
    output logic [3:0]      we_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misalign_o
);

    // Misalignment only flags; enables are still produced so the core decides what to do.
    always_comb begin
        we_o       = 4'b0000;
        wdata_o    = '0;
        misalign_o = 1'b0;
        case (func_i)
            SB: begin
                we_o    = 4'b0001 << addr_i;
                wdata_o = {4{rv2_i[7:0]}};
            end
            SH: begin
                we_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{rv2_i[15:0]}};
                misalign_o = addr_i[0];
            end
            SW: begin
                we_o       = 4'b1111;
                wdata_o    = rv2_i;
                misalign_o = |addr_i;
            end
            default: begin
                we_o       = 4'b0000;
                wdata_o    = '0;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/s_type.sv
// rtl/s_type.sv - S-type store unit: lane alignment plus sticky fault flag and store counter
module s_type
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    Instr_IO.S_type_io_ports io
);

    s_func           func_w;
    logic [3:0]      we_w;
    logic [XLEN-1:0] wdata_w;
    logic            misalign_w;

    logic            fault_q, fault_d;
    logic [XLEN-1:0] cnt_q, cnt_d;

    // Opcode is not checked; the top-level decoder only uses these outputs on S-type cycles.
    assign func_w = s_func'({io.idata[30], io.idata[25], io.idata[14:12]});

    logic unused_bits;
    assign unused_bits = ^{io.iaddr, io.idata[31], io.idata[29:26], io.idata[24:15],
                           io.idata[11:0], io.daddr[XLEN-1:2]};

    s_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .func_i    (func_w),
        .addr_i    (io.daddr[1:0]),
        .rv2_i     (io.rv2),
        .we_o      (we_w),
        .wdata_o   (wdata_w),
        .misalign_o(misalign_w)
    );

    always_comb begin
        fault_d = fault_q | misalign_w;
        cnt_d   = cnt_q;
        if (we_w != 4'b0000) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge io.clk or posedge io.reset) begin
        if (io.reset) begin
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.we_S       = we_w;
    assign io.wdata_S    = wdata_w;
    assign io.misalign_S = misalign_w;
    assign io.fault_S    = fault_q;
    assign io.store_cnt  = cnt_q;

endmodule

// File: tb/tb_s_type.sv
// tb/tb_s_type.sv - self-checking bench for s_type: vector table plus clocked sequences
module tb_s_type;
    import riscv_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic        b30;
        logic        b25;
        logic [1:0]  alo;
        logic [31:0] rv2;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    Instr_IO #(.XLEN(32)) io ();

    s_type #(.XLEN(32)) dut (
        .io(io.S_type_io_ports)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 io.clk = ~io.clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic b30, input logic b25,
                                input logic [1:0] alo, input logic [31:0] rv2,
                                input logic [3:0] we, input logic [31:0] wd, input logic mis);
        vec_t v;
        v.f3 = f3; v.b30 = b30; v.b25 = b25; v.alo = alo; v.rv2 = rv2;
        v.exp_we = we; v.exp_wdata = wd; v.exp_mis = mis;
        return v;
    endfunction

    task automatic drive_store(input logic [2:0] f3, input logic b30, input logic b25,
                               input logic [1:0] alo, input logic [31:0] rv2);
        logic [31:0] id;
        logic [31:0] da;
        id       = $urandom;
        id[30]   = b30;
        id[25]   = b25;
        id[14:12] = f3;
        da       = $urandom;
        da[1:0]  = alo;
        io.idata = id;
        io.daddr = da;
        io.rv2   = rv2;
        io.iaddr = $urandom;
    endtask

    initial begin
        io.clk   = 1'b0;
        io.reset = 1'b1;
        io.idata = '0;
        io.iaddr = '0;
        io.daddr = '0;
        io.rv2   = '0;

        vecs.push_back(mk(F3_SB, 0, 0, 2'd1, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 0));
        vecs.push_back(mk(F3_SB, 0, 0, 2'd0, 32'h1234_5678, 4'b0001, 32'h7878_7878, 0));
        vecs.push_back(mk(F3_SB, 0, 0, 2'd1, 32'h1234_5678, 4'b0010, 32'h7878_7878, 0));
        vecs.push_back(mk(F3_SB, 0, 0, 2'd2, 32'h1234_5678, 4'b0100, 32'h7878_7878, 0));
        vecs.push_back(mk(F3_SB, 0, 0, 2'd3, 32'h1234_5678, 4'b1000, 32'h7878_7878, 0));
        vecs.push_back(mk(F3_SH, 0, 0, 2'd0, 32'hDEAD_BEEF, 4'b0011, 32'hBEEF_BEEF, 0));
        vecs.push_back(mk(F3_SH, 0, 0, 2'd1, 32'hDEAD_BEEF, 4'b0011, 32'hBEEF_BEEF, 1));
        vecs.push_back(mk(F3_SH, 0, 0, 2'd2, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 0));
        vecs.push_back(mk(F3_SH, 0, 0, 2'd3, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 1));
        vecs.push_back(mk(F3_SW, 0, 0, 2'd0, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0));
        vecs.push_back(mk(F3_SW, 0, 0, 2'd1, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1));
        vecs.push_back(mk(F3_SW, 0, 0, 2'd2, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1));
        vecs.push_back(mk(F3_SW, 0, 0, 2'd3, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1));
        vecs.push_back(mk(3'b011, 0, 0, 2'd1, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 0));
        vecs.push_back(mk(3'b100, 0, 0, 2'd0, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 0));
        vecs.push_back(mk(F3_SB, 1, 0, 2'd0, 32'h0000_00AB, 4'b0000, 32'h0000_0000, 0));
        vecs.push_back(mk(F3_SW, 0, 1, 2'd1, 32'hCAFE_F00D, 4'b0000, 32'h0000_0000, 0));

        #2;
        check("reset_fault", {31'b0, io.fault_S}, 32'd0);
        check("reset_cnt", io.store_cnt, 32'd0);

        // Combinational table applied while reset is held: outputs must still respond.
        foreach (vecs[i]) begin
            exp_t e;
            @(negedge io.clk);
            drive_store(vecs[i].f3, vecs[i].b30, vecs[i].b25, vecs[i].alo, vecs[i].rv2);
            e.we = vecs[i].exp_we; e.wdata = vecs[i].exp_wdata; e.mis = vecs[i].exp_mis;
            sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            check($sformatf("v%0d_we", i), {28'b0, io.we_S}, {28'b0, e.we});
            check($sformatf("v%0d_wdata", i), io.wdata_S, e.wdata);
            check($sformatf("v%0d_mis", i), {31'b0, io.misalign_S}, {31'b0, e.mis});
        end
        check("held_reset_cnt", io.store_cnt, 32'd0);
        check("held_reset_fault", {31'b0, io.fault_S}, 32'd0);

        // Non-store funct3 must not count.
        @(negedge io.clk);
        drive_store(3'b011, 0, 0, 2'd0, 32'h1);
        io.reset = 1'b0;
        repeat (2) @(posedge io.clk);
        #1;
        check("nostore_cnt", io.store_cnt, 32'd0);
        check("nostore_fault", {31'b0, io.fault_S}, 32'd0);

        // Misaligned SW: fault sets on the edge and sticks.
        @(negedge io.clk);
        drive_store(F3_SW, 0, 0, 2'd1, 32'h5555_AAAA);
        #1;
        check("sw_mis_comb", {31'b0, io.misalign_S}, 32'd1);
        check("sw_fault_pre", {31'b0, io.fault_S}, 32'd0);
        @(posedge io.clk); #1;
        check("sw_fault_set", {31'b0, io.fault_S}, 32'd1);
        check("sw_cnt", io.store_cnt, 32'd1);
        @(negedge io.clk);
        drive_store(3'b111, 0, 0, 2'd0, 32'h0);
        repeat (3) @(posedge io.clk);
        #1;
        check("fault_sticky", {31'b0, io.fault_S}, 32'd1);
        check("cnt_idle", io.store_cnt, 32'd1);

        @(negedge io.clk); #2;
        io.reset = 1'b1;
        #1;
        check("rst1_fault", {31'b0, io.fault_S}, 32'd0);
        check("rst1_cnt", io.store_cnt, 32'd0);
        @(negedge io.clk);
        io.reset = 1'b0;

        // Three aligned stores, then asynchronous reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge io.clk);
            drive_store(F3_SB, 0, 0, k[1:0], 32'h0000_0011 + k);
        end
        @(posedge io.clk); #1;
        check("three_cnt", io.store_cnt, 32'd3);
        check("three_fault", {31'b0, io.fault_S}, 32'd0);
        @(negedge io.clk);
        drive_store(F3_SH, 0, 0, 2'd3, 32'h0000_1234);
        #2;
        io.reset = 1'b1;
        #1;
        check("rst2_cnt", io.store_cnt, 32'd0);
        check("rst2_fault", {31'b0, io.fault_S}, 32'd0);
        // Reset held across an edge with a counting, faulting store present must win.
        @(posedge io.clk); #1;
        check("rst_win_cnt", io.store_cnt, 32'd0);
        check("rst_win_fault", {31'b0, io.fault_S}, 32'd0);
        check("rst_comb_we", {28'b0, io.we_S}, 32'h0000_000C);
        @(negedge io.clk);
        io.reset = 1'b0;
        @(posedge io.clk); #1;
        check("post_rst_cnt", io.store_cnt, 32'd1);
        check("post_rst_fault", {31'b0, io.fault_S}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
